emc_xmem_responder: RTL and testbench
=====================================

# emc_xmem_responder

External program-memory responder for the EMC08 top level. Completes the core's external fetch cycle (ALE address phase, then PSEN_B read strobe) on the port 0/port 2 pads. It captures the 16-bit fetch address, fetches the opcode byte from a backing memory over a req/ack handshake, and drives it onto the P0 pad data path while PSEN_B is low. It sits between the pad control signals (p0/p2 y inputs, p0 a/en outputs) and the off-core program-store model or flash bridge, and is used when ea_b selects external program memory.

## Interface
Parameters:
- XMR_TIMEOUT, 8: maximum cycles in FETCH without ack before abort (legal range 2..255).
- XMR_FILL, 8'hFF: byte driven on timeout (floating-bus value).

Ports:
- xmr_clock_i  in  1  system clock; all state on rising edge.
- xmr_reset_i  in  1  asynchronous, active-low reset.
- xmr_ale_i  in  1  address latch enable from core; high during address phase.
- xmr_psen_b_i  in  1  program store enable, active-low read strobe.
- xmr_p0_y_i  in  8  P0 pad input; low address byte while ALE high.
- xmr_p2_y_i  in  8  P2 pad input; high address byte.
- xmr_p0_a_o  out  8  data to P0 pad driver.
- xmr_p0_en_o  out  1  P0 pad drive enable, high only in DRIVE.
- xmr_mem_req_o  out  1  backing-memory read request, level.
- xmr_mem_addr_o  out  16  backing-memory byte address.
- xmr_mem_ack_i  in  1  one-cycle acknowledge; data valid same cycle.
- xmr_mem_data_i  in  8  backing-memory read data.
- xmr_err_o  out  1  sticky error flag (timeout).
- xmr_fetch_cnt_o  out  16  count of completed fetches, wraps 16'hFFFF->0.

## Operation
- Reset (xmr_reset_i=0, async): state IDLE. All outputs 0. Address latch, data register, timeout counter, ale_q all 0.
- Address latch: addr_lat <= {p2_y, p0_y} every cycle ale_i=1. Holds while ale_i=0. ale_q is ale_i delayed one cycle.
- ALE fall: ale_q=1 and ale_i=0, i.e. addr_lat holds the value from the last ALE-high cycle.
- IDLE: on ALE fall: mem_addr_o <= addr_lat, mem_req_o <= 1, tcnt <= 0, go FETCH. PSEN_B low in IDLE is ignored.
- FETCH: mem_req_o held high until ack or timeout. ALE activity does not cancel FETCH.
  - ack=1: data_q <= mem_data_i, mem_req_o <= 0. If psen_b_i=0 this cycle, go DRIVE (p0_en_o <= 1); else go HOLD.
  - No ack and tcnt = XMR_TIMEOUT-1: mem_req_o <= 0, data_q <= XMR_FILL, err_o <= 1, then same psen test as ack.
  - Otherwise tcnt++.
- HOLD: ale_i=1 -> IDLE (fetch discarded). Else psen_b_i=0 -> DRIVE, p0_en_o <= 1.
- DRIVE: p0_a_o = data_q.
  - psen_b_i=1 -> p0_en_o <= 0, fetch_cnt++, go IDLE.
  - ale_i=1 (protocol violation) -> p0_en_o <= 0, go IDLE, no count. Takes priority over the psen_b_i rule.
- p0_a_o is loaded from data_q when entering DRIVE and holds its last value afterwards.
- Ack arriving outside FETCH is ignored.
- err_o clears only on reset.

## Timing
- ALE fall sampled at edge k: mem_req_o=1 and mem_addr_o valid after edge k.
- Ack sampled at edge m: mem_req_o=0 after edge m.
- Read latency: psen_b_i sampled low at edge n with data ready (HOLD) -> p0_en_o=1 after edge n (one cycle).
- If ack and psen-low coincide in FETCH, p0_en_o=1 after that same edge.
- PSEN_B rise sampled at edge r -> p0_en_o=0 after edge r. No drive cycle overlaps a following ALE-high cycle.
- Timeout: with no ack, mem_req_o is high for exactly XMR_TIMEOUT cycles.
- Reset mid-cycle: p0_en_o and mem_req_o drop immediately (async), with no wait for clock.

## Test plan
- Basic fetch: ALE high with p2=8'h12, p0=8'h34, then ALE low; ack=1 with data 8'hA5 two cycles after req; PSEN_B low 4 cycles -> mem_addr_o=16'h1234; p0_a_o=8'hA5, p0_en_o=1 one cycle after PSEN_B low; drops one cycle after PSEN_B rise; fetch_cnt_o=1.
- Coincident ack/PSEN: PSEN_B low already when ack arrives with 8'h3C -> FETCH->DRIVE directly; p0_en_o=1 the next cycle, p0_a_o=8'h3C.
- Timeout: no ack -> req high exactly 8 cycles; then err_o=1, p0_a_o=8'hFF driven during PSEN_B low. Late ack ignored and err_o stays 1.
- Back-to-back fetches: 3 ALE/PSEN cycles to 16'h0000, 16'h0001, 16'hFFFF -> correct addresses; p0_en_o low during every ALE-high cycle; fetch_cnt_o=3.
- ALE during DRIVE: ALE rises while PSEN_B still low -> p0_en_o=0 next cycle; fetch_cnt_o not incremented.
- Reset mid-operation: reset asserted in FETCH and again in DRIVE -> mem_req_o, p0_en_o, err_o and fetch_cnt_o all 0 asynchronously; a normal fetch completes after release.

Source files
------------

// File: rtl/emc_xmem_responder.sv
// External program-memory responder: latches the ALE fetch address, reads the
// opcode byte from a backing store over req/ack, and drives it on P0 while PSEN_B is low.
module emc_xmem_responder #(
    parameter int unsigned XMR_TIMEOUT = 8,
    parameter logic [7:0]  XMR_FILL    = 8'hFF
) (
    input  logic        xmr_clock_i,
    input  logic        xmr_reset_i,
    input  logic        xmr_ale_i,
    input  logic        xmr_psen_b_i,
    input  logic [7:0]  xmr_p0_y_i,
    input  logic [7:0]  xmr_p2_y_i,
    output logic [7:0]  xmr_p0_a_o,
    output logic        xmr_p0_en_o,
    output logic        xmr_mem_req_o,
    output logic [15:0] xmr_mem_addr_o,
    input  logic        xmr_mem_ack_i,
    input  logic [7:0]  xmr_mem_data_i,
    output logic        xmr_err_o,
    output logic [15:0] xmr_fetch_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DRIVE} state_t;

    localparam logic [7:0] TCNT_LAST = 8'(XMR_TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [15:0] addr_lat_q, addr_lat_d;
    logic        ale_q, ale_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  tcnt_q, tcnt_d;
    logic        req_q, req_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [7:0]  p0_a_q, p0_a_d;
    logic        p0_en_q, p0_en_d;
    logic        err_q, err_d;
    logic [15:0] fetch_cnt_q, fetch_cnt_d;
    logic [7:0]  fetch_byte;

    // On timeout the floating-bus value stands in for the missing opcode.
    assign fetch_byte = xmr_mem_ack_i ? xmr_mem_data_i : XMR_FILL;

    always_comb begin
        state_d     = state_q;
        addr_lat_d  = addr_lat_q;
        ale_d       = xmr_ale_i;
        data_d      = data_q;
        tcnt_d      = tcnt_q;
        req_d       = req_q;
        mem_addr_d  = mem_addr_q;
        p0_a_d      = p0_a_q;
        p0_en_d     = p0_en_q;
        err_d       = err_q;
        fetch_cnt_d = fetch_cnt_q;

        if (xmr_ale_i) begin
            addr_lat_d = {xmr_p2_y_i, xmr_p0_y_i};
        end

        case (state_q)
            S_IDLE: begin
                if (ale_q && !xmr_ale_i) begin
                    mem_addr_d = addr_lat_q;
                    req_d      = 1'b1;
                    tcnt_d     = 8'd0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                if (xmr_mem_ack_i || (tcnt_q == TCNT_LAST)) begin
                    req_d  = 1'b0;
                    data_d = fetch_byte;
                    if (!xmr_mem_ack_i) begin
                        err_d = 1'b1;
                    end
                    if (!xmr_psen_b_i) begin
                        p0_en_d = 1'b1;
                        p0_a_d  = fetch_byte;
                        state_d = S_DRIVE;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    tcnt_d = tcnt_q + 8'd1;
                end
            end
            S_HOLD: begin
                if (xmr_ale_i) begin
                    state_d = S_IDLE;
                end else if (!xmr_psen_b_i) begin
                    p0_en_d = 1'b1;
                    p0_a_d  = data_q;
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                // A new address phase while still driving aborts without counting.
                if (xmr_ale_i) begin
                    p0_en_d = 1'b0;
                    state_d = S_IDLE;
                end else if (xmr_psen_b_i) begin
                    p0_en_d     = 1'b0;
                    fetch_cnt_d = fetch_cnt_q + 16'd1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge xmr_clock_i or negedge xmr_reset_i) begin
        if (!xmr_reset_i) begin
            state_q     <= S_IDLE;
            addr_lat_q  <= 16'd0;
            ale_q       <= 1'b0;
            data_q      <= 8'd0;
            tcnt_q      <= 8'd0;
            req_q       <= 1'b0;
            mem_addr_q  <= 16'd0;
            p0_a_q      <= 8'd0;
            p0_en_q     <= 1'b0;
            err_q       <= 1'b0;
            fetch_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_lat_q  <= addr_lat_d;
            ale_q       <= ale_d;
            data_q      <= data_d;
            tcnt_q      <= tcnt_d;
            req_q       <= req_d;
            mem_addr_q  <= mem_addr_d;
            p0_a_q      <= p0_a_d;
            p0_en_q     <= p0_en_d;
            err_q       <= err_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign xmr_p0_a_o      = p0_a_q;
    assign xmr_p0_en_o     = p0_en_q;
    assign xmr_mem_req_o   = req_q;
    assign xmr_mem_addr_o  = mem_addr_q;
    assign xmr_err_o       = err_q;
    assign xmr_fetch_cnt_o = fetch_cnt_q;

endmodule

// File: tb/tb_emc_xmem_responder.sv
// Directed bench for emc_xmem_responder: address capture, fetch handshake,
// PSEN drive timing, timeout fill, ALE abort and asynchronous reset.
module tb_emc_xmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ale;
    logic        psen_b;
    logic [7:0]  p0_y;
    logic [7:0]  p2_y;
    logic [7:0]  p0_a;
    logic        p0_en;
    logic        req;
    logic [15:0] mem_addr;
    logic        ack;
    logic [7:0]  mem_data;
    logic        err;
    logic [15:0] fetch_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    emc_xmem_responder #(.XMR_TIMEOUT(8), .XMR_FILL(8'hFF)) dut (
        .xmr_clock_i    (clk),
        .xmr_reset_i    (rst_n),
        .xmr_ale_i      (ale),
        .xmr_psen_b_i   (psen_b),
        .xmr_p0_y_i     (p0_y),
        .xmr_p2_y_i     (p2_y),
        .xmr_p0_a_o     (p0_a),
        .xmr_p0_en_o    (p0_en),
        .xmr_mem_req_o  (req),
        .xmr_mem_addr_o (mem_addr),
        .xmr_mem_ack_i  (ack),
        .xmr_mem_data_i (mem_data),
        .xmr_err_o      (err),
        .xmr_fetch_cnt_o(fetch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ALE pulse for one cycle, then ALE low: request is up after the fall edge.
    task automatic addr_phase(input logic [15:0] a);
        ale  = 1'b1;
        p2_y = a[15:8];
        p0_y = a[7:0];
        tick();
        chk("en_low_in_ale", {31'd0, p0_en}, 32'd0);
        ale = 1'b0;
        tick();
        chk("req_after_fall", {31'd0, req}, 32'd1);
        chk("mem_addr", {16'd0, mem_addr}, {16'd0, a});
    endtask

    task automatic full_fetch(input logic [15:0] a, input logic [7:0] d);
        addr_phase(a);
        ack      = 1'b1;
        mem_data = d;
        tick();
        ack    = 1'b0;
        psen_b = 1'b0;
        tick();
        chk("ff_en", {31'd0, p0_en}, 32'd1);
        chk("ff_data", {24'd0, p0_a}, {24'd0, d});
        psen_b = 1'b1;
        tick();
        chk("ff_en_drop", {31'd0, p0_en}, 32'd0);
    endtask

    initial begin
        int n_req;
        rst_n    = 1'b0;
        ale      = 1'b0;
        psen_b   = 1'b1;
        p0_y     = 8'h00;
        p2_y     = 8'h00;
        ack      = 1'b0;
        mem_data = 8'h00;
        tick();
        tick();
        chk("rst_en", {31'd0, p0_en}, 32'd0);
        chk("rst_req", {31'd0, req}, 32'd0);
        chk("rst_a", {24'd0, p0_a}, 32'd0);
        chk("rst_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic fetch, ack two cycles after request, PSEN low for four cycles
        addr_phase(16'h1234);
        tick();
        chk("basic_req_wait", {31'd0, req}, 32'd1);
        ack      = 1'b1;
        mem_data = 8'hA5;
        tick();
        ack = 1'b0;
        chk("basic_req_drop", {31'd0, req}, 32'd0);
        chk("basic_en_hold", {31'd0, p0_en}, 32'd0);
        psen_b = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("basic_en", {31'd0, p0_en}, 32'd1);
            chk("basic_data", {24'd0, p0_a}, 32'hA5);
        end
        psen_b = 1'b1;
        tick();
        chk("basic_en_drop", {31'd0, p0_en}, 32'd0);
        chk("basic_cnt", {16'd0, fetch_cnt}, 32'd1);
        chk("basic_a_holds", {24'd0, p0_a}, 32'hA5);

        // Ack and PSEN low coincide in FETCH
        addr_phase(16'h5678);
        psen_b = 1'b0;
        tick();
        chk("coin_no_en_yet", {31'd0, p0_en}, 32'd0);
        ack      = 1'b1;
        mem_data = 8'h3C;
        tick();
        ack = 1'b0;
        chk("coin_en", {31'd0, p0_en}, 32'd1);
        chk("coin_data", {24'd0, p0_a}, 32'h3C);
        psen_b = 1'b1;
        tick();
        chk("coin_cnt", {16'd0, fetch_cnt}, 32'd2);

        // Timeout: request stays up exactly 8 cycles, then fill byte is driven
        addr_phase(16'h9ABC);
        n_req = 0;
        for (int i = 0; i < 20; i++) begin
            if (!req) break;
            n_req++;
            tick();
        end
        chk("tmo_req_cycles", n_req, 32'd8);
        chk("tmo_err", {31'd0, err}, 32'd1);
        ack      = 1'b1;
        mem_data = 8'h00;
        psen_b   = 1'b0;
        tick();
        ack = 1'b0;
        chk("tmo_en", {31'd0, p0_en}, 32'd1);
        chk("tmo_fill", {24'd0, p0_a}, 32'hFF);
        chk("tmo_req_stays_low", {31'd0, req}, 32'd0);
        psen_b = 1'b1;
        tick();
        chk("tmo_err_sticky", {31'd0, err}, 32'd1);
        chk("tmo_cnt", {16'd0, fetch_cnt}, 32'd3);

        // Async reset clears the sticky error and count without a clock edge
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst2_err", {31'd0, err}, 32'd0);
        chk("rst2_cnt", {16'd0, fetch_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Back-to-back fetches including address extremes
        full_fetch(16'h0000, 8'h11);
        full_fetch(16'h0001, 8'h22);
        full_fetch(16'hFFFF, 8'h33);
        chk("b2b_cnt", {16'd0, fetch_cnt}, 32'd3);

        // ALE rises during DRIVE: drive aborts, no count
        addr_phase(16'h4242);
        ack      = 1'b1;
        mem_data = 8'h77;
        psen_b   = 1'b0;
        tick();
        ack = 1'b0;
        chk("abort_en_on", {31'd0, p0_en}, 32'd1);
        ale  = 1'b1;
        p2_y = 8'hBE;
        p0_y = 8'hEF;
        tick();
        chk("abort_en_off", {31'd0, p0_en}, 32'd0);
        chk("abort_cnt", {16'd0, fetch_cnt}, 32'd3);
        psen_b = 1'b1;
        ale    = 1'b0;
        tick();
        chk("abort_new_req", {31'd0, req}, 32'd1);
        chk("abort_new_addr", {16'd0, mem_addr}, 32'hBEEF);

        // Reset while in FETCH
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstf_req", {31'd0, req}, 32'd0);
        chk("rstf_en", {31'd0, p0_en}, 32'd0);
        chk("rstf_cnt", {16'd0, fetch_cnt}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Reset while in DRIVE
        addr_phase(16'h2468);
        ack      = 1'b1;
        mem_data = 8'h5A;
        psen_b   = 1'b0;
        tick();
        ack = 1'b0;
        chk("rstd_en_on", {31'd0, p0_en}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstd_en", {31'd0, p0_en}, 32'd0);
        chk("rstd_err", {31'd0, err}, 32'd0);
        chk("rstd_a", {24'd0, p0_a}, 32'd0);
        psen_b = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

        full_fetch(16'hC0DE, 8'h96);
        chk("post_rst_cnt", {16'd0, fetch_cnt}, 32'd1);
        chk("post_rst_err", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
